// File: rtl/alu_defs_pkg.sv
// ALU op-code constants and the sharing-controller FSM encoding.
// Shared by the ALU and by alu_share_ctrl.
package alu_defs_pkg;

    // ALU operation codes (ALUOperation input)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;

    // Requester index recorded after reset so requester 0 wins the first tie
    localparam logic LAST_GRANT_RST = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,  // waiting for a request
        StExec = 2'd1,  // ALU inputs registered, ALU settling
        StResp = 2'd2   // result registered, response pulse out
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input combinational grant from the request valids and the last grant.
// Optional macro ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins a tie.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
    // Last grant only steers the response in this build, not arbitration
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

    // Grant index: sole requester wins, a tie goes by policy
    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        o_grant       = 1'b0;
        if (i_valid0 && i_valid1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            o_grant = 1'b0;
`else
            o_grant = ~i_last_grant;
`endif
        end else if (i_valid1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. The winner's operation
// is registered onto the ALU inputs, the result is captured one cycle later
// and returned with a one-cycle response pulse (accept N, pulse N+2).
// Optional macro ALU_SHARE_FIXED_PRIO_EN: fixed priority to requester 0.
module alu_share_ctrl
    import alu_defs_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned OPW = 4,
    parameter int unsigned SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [SHW-1:0] req0_shamt,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [SHW-1:0] req1_shamt,
    output logic           rsp0_valid,
    output logic           rsp1_valid,
    output logic [DW-1:0]  rsp_result,
    output logic           rsp_zero,
    output logic           busy,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [SHW-1:0] alu_shamt,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero
);

    state_e         r_state;
    state_e         w_state_nxt;
    logic           r_last_grant;
    logic           w_gnt_valid;
    logic           w_gnt;
    logic           w_accept;

    logic [OPW-1:0] r_alu_op;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [SHW-1:0] r_alu_shamt;
    logic [OPW-1:0] w_sel_op;
    logic [DW-1:0]  w_sel_a;
    logic [DW-1:0]  w_sel_b;
    logic [SHW-1:0] w_sel_shamt;

    logic [DW-1:0]  r_rsp_result;
    logic           r_rsp_zero;

    rr_arb2 u_arb (
        .i_valid0      (req0_valid),
        .i_valid1      (req1_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_gnt_valid),
        .o_grant       (w_gnt)
    );

    // Ready is combinational on valid; only one winner can be ready
    assign w_accept   = (r_state == StIdle) && w_gnt_valid;
    assign req0_ready = w_accept && !w_gnt;
    assign req1_ready = w_accept && w_gnt;

    // Operand mux for the granted requester
    always_comb begin
        w_sel_op    = req0_op;
        w_sel_a     = req0_a;
        w_sel_b     = req0_b;
        w_sel_shamt = req0_shamt;
        if (w_gnt) begin
            w_sel_op    = req1_op;
            w_sel_a     = req1_a;
            w_sel_b     = req1_b;
            w_sel_shamt = req1_shamt;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StExec;
            StExec:  w_state_nxt = StResp;
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last grant: recorded on accept, steers the response and the next tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (w_accept) begin
            r_last_grant <= w_gnt;
        end
    end

    // ALU input registers: load the winner on accept, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_shamt <= '0;
        end else if (w_accept) begin
            r_alu_op    <= w_sel_op;
            r_alu_a     <= w_sel_a;
            r_alu_b     <= w_sel_b;
            r_alu_shamt <= w_sel_shamt;
        end
    end

    // Result capture at the end of EXEC, held until the next capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (r_state == StExec) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_shamt  = r_alu_shamt;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != StIdle);
    // Pulse decoded from flops only, so it is glitch-free
    assign rsp0_valid = (r_state == StResp) && !r_last_grant;
    assign rsp1_valid = (r_state == StResp) && r_last_grant;

endmodule
